// File: rtl/fluid_ctrl_pkg.sv
// Shared types and helpers for the fluid dose sequencer.
// Holds the controller state encoding and a width helper for channel indices.
package fluid_ctrl_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StDose   = 3'd1,
    StSettle = 3'd2,
    StMix    = 3'd3,
    StFlush  = 3'd4,
    StDone   = 3'd5
  } fluid_state_e;

  // Index width that never collapses to zero for a single channel.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fluid_dose_sequencer_if.sv
// Control/status bundle between a run initiator and the dose sequencer.
// The sequencer takes the slave side; the initiator drives the master side.
interface fluid_dose_sequencer_if #(
  parameter int unsigned NUM_SOLN = 3,
  parameter int unsigned CNT_W    = 16
);

  localparam int unsigned ChanW = fluid_ctrl_pkg::clog2_min1(NUM_SOLN);

  logic                      start;
  logic                      abort;
  logic [NUM_SOLN-1:0]       chan_mask;
  logic [NUM_SOLN*CNT_W-1:0] dose_len;
  logic [NUM_SOLN-1:0]       valve_en;
  logic                      mix_pump;
  logic                      flush_valve;
  logic                      busy;
  logic                      done;
  logic                      aborted;
  logic                      err_empty;
  logic [ChanW-1:0]          cur_chan;

  modport master (
    output start, abort, chan_mask, dose_len,
    input  valve_en, mix_pump, flush_valve, busy, done, aborted, err_empty, cur_chan
  );

  modport slave (
    input  start, abort, chan_mask, dose_len,
    output valve_en, mix_pump, flush_valve, busy, done, aborted, err_empty, cur_chan
  );

endinterface

// File: rtl/fluid_dur_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// Loading N-1 makes expire rise on the Nth cycle after the load edge.
module fluid_dur_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/fluid_dose_sequencer.sv
// Sequential inlet dosing controller: doses each effective channel in ascending order,
// then runs the mixer pump and the flush valve, with abort and start/done handshake.
module fluid_dose_sequencer
  import fluid_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SOLN      = 3,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MIX_CYCLES    = 300,
  parameter int unsigned FLUSH_CYCLES  = 100
) (
  input logic                 clk,
  input logic                 rst,
  fluid_dose_sequencer_if.slave bus
);

  localparam int unsigned ChanW = clog2_min1(NUM_SOLN);

  fluid_state_e              state_q, state_d;
  logic [ChanW-1:0]          chan_q, chan_d;
  logic                      abort_flag_q, abort_flag_d;
  logic [NUM_SOLN-1:0]       mask_q;
  logic [NUM_SOLN*CNT_W-1:0] lens_q;

  logic [NUM_SOLN-1:0]       mask_src, eff_src;
  logic [NUM_SOLN*CNT_W-1:0] lens_src;
  int                        search_from;
  logic                      nxt_found;
  logic [ChanW-1:0]          nxt_idx;
  logic                      accept;
  logic                      tmr_load, tmr_expire;
  logic [CNT_W-1:0]          tmr_value;

  logic [NUM_SOLN-1:0]       valve_en_q, valve_en_d;
  logic                      mix_pump_q, mix_pump_d;
  logic                      flush_valve_q, flush_valve_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic                      err_empty_q, err_empty_d;
  logic [ChanW-1:0]          cur_chan_q, cur_chan_d;

  // In IDLE the search looks at the live inputs so the first channel is known at accept.
  assign mask_src    = (state_q == StIdle) ? bus.chan_mask : mask_q;
  assign lens_src    = (state_q == StIdle) ? bus.dose_len : lens_q;
  assign search_from = (state_q == StIdle) ? 0 : int'(chan_q) + 1;

  always_comb begin
    eff_src   = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = 0; i < NUM_SOLN; i++) begin
      eff_src[i] = mask_src[i] && (lens_src[i*CNT_W +: CNT_W] != '0);
    end
    for (int i = NUM_SOLN - 1; i >= 0; i--) begin
      if (eff_src[i] && (i >= search_from)) begin
        nxt_found = 1'b1;
        nxt_idx   = ChanW'(i);
      end
    end
  end

  fluid_dur_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      chan_q        <= '0;
      abort_flag_q  <= 1'b0;
      mask_q        <= '0;
      lens_q        <= '0;
      valve_en_q    <= '0;
      mix_pump_q    <= 1'b0;
      flush_valve_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_empty_q   <= 1'b0;
      cur_chan_q    <= '0;
    end else begin
      state_q       <= state_d;
      chan_q        <= chan_d;
      abort_flag_q  <= abort_flag_d;
      if (accept) begin
        mask_q <= bus.chan_mask;
        lens_q <= bus.dose_len;
      end
      valve_en_q    <= valve_en_d;
      mix_pump_q    <= mix_pump_d;
      flush_valve_q <= flush_valve_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      err_empty_q   <= err_empty_d;
      cur_chan_q    <= cur_chan_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    abort_flag_d = abort_flag_q;
    accept       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && nxt_found) begin
          accept       = 1'b1;
          state_d      = StDose;
          chan_d       = nxt_idx;
          abort_flag_d = 1'b0;
        end
      end
      StDose, StSettle, StMix: begin
        if (bus.abort) begin
          state_d      = StFlush;
          abort_flag_d = 1'b1;
        end else if (tmr_expire) begin
          if (state_q == StDose) begin
            state_d = nxt_found ? StSettle : StMix;
          end else if (state_q == StSettle) begin
            state_d = StDose;
            chan_d  = nxt_idx;
          end else begin
            state_d = StFlush;
          end
        end
      end
      StFlush: if (tmr_expire) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Every phase change reloads the shared timer with the new phase length minus one.
  always_comb begin
    tmr_load  = (state_d != state_q);
    tmr_value = '0;
    case (state_d)
      StDose:   tmr_value = lens_src[int'(chan_d)*CNT_W +: CNT_W] - 1'b1;
      StSettle: tmr_value = CNT_W'(SETTLE_CYCLES - 1);
      StMix:    tmr_value = CNT_W'(MIX_CYCLES - 1);
      StFlush:  tmr_value = CNT_W'(FLUSH_CYCLES - 1);
      default:  tmr_value = '0;
    endcase
  end

  // Outputs decode the next state so they are registered yet aligned with it.
  always_comb begin
    valve_en_d    = '0;
    if (state_d == StDose) valve_en_d[chan_d] = 1'b1;
    mix_pump_d    = (state_d == StMix);
    flush_valve_d = (state_d == StFlush);
    busy_d        = (state_d == StDose) || (state_d == StSettle) ||
                    (state_d == StMix) || (state_d == StFlush);
    done_d        = (state_d == StDone);
    aborted_d     = (state_d == StDone) && abort_flag_d;
    err_empty_d   = (state_q == StIdle) && bus.start && !nxt_found;
    cur_chan_d    = ((state_d == StDose) || (state_d == StSettle)) ? chan_d : '0;
  end

  assign bus.valve_en    = valve_en_q;
  assign bus.mix_pump    = mix_pump_q;
  assign bus.flush_valve = flush_valve_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.err_empty   = err_empty_q;
  assign bus.cur_chan    = cur_chan_q;

endmodule

// File: tb/tb_fluid_dose_sequencer.sv
// Self-checking bench: a phase-timeline model predicts every output per cycle,
// with literal pins on the model and a narrow-counter instance for the no-wrap case.
module tb_fluid_dose_sequencer;

  localparam int unsigned NS = 3, CW = 16, SC = 2, MC = 5, FC = 3;
  localparam int MAXC = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fluid_dose_sequencer_if #(.NUM_SOLN(NS), .CNT_W(CW)) bus ();
  fluid_dose_sequencer_if #(.NUM_SOLN(2), .CNT_W(4)) bus2 ();

  fluid_dose_sequencer #(
    .NUM_SOLN(NS), .CNT_W(CW), .SETTLE_CYCLES(SC), .MIX_CYCLES(MC), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  fluid_dose_sequencer #(
    .NUM_SOLN(2), .CNT_W(4), .SETTLE_CYCLES(SC), .MIX_CYCLES(MC), .FLUSH_CYCLES(FC)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [NS-1:0] e_valve[MAXC];
  logic [1:0]    e_chan[MAXC];
  logic          e_pump[MAXC], e_flush[MAXC], e_busy[MAXC], e_done[MAXC];
  logic          e_abt[MAXC], e_err[MAXC];
  int            rel = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: list the phase of every cycle, then derive the outputs from it.
  // Phase codes: 0 idle, 1 dose, 2 settle, 3 mix, 4 flush, 5 done.
  task automatic build_model(input logic [2:0] mask, input int l0, input int l1, input int l2,
                             input int abort_at, input int reset_at);
    int ph[MAXC];
    int ch[MAXC];
    int lens[3];
    int eff[$];
    int t;
    bit ab;
    lens = '{l0, l1, l2};
    ab = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      ph[c] = 0; ch[c] = 0; e_err[c] = 1'b0;
    end
    for (int i = 0; i < 3; i++) if (mask[i] && lens[i] != 0) eff.push_back(i);
    if (eff.size() == 0) begin
      e_err[1] = 1'b1;
    end else begin
      t = 1;
      for (int k = 0; k < eff.size(); k++) begin
        for (int j = 0; j < lens[eff[k]]; j++) begin ph[t] = 1; ch[t] = eff[k]; t++; end
        if (k < eff.size() - 1)
          for (int j = 0; j < SC; j++) begin ph[t] = 2; ch[t] = eff[k]; t++; end
      end
      for (int j = 0; j < MC; j++) begin ph[t] = 3; t++; end
      for (int j = 0; j < FC; j++) begin ph[t] = 4; t++; end
      ph[t] = 5;
      if (abort_at >= 0 && ph[abort_at] >= 1 && ph[abort_at] <= 3) begin
        ab = 1'b1;
        t = abort_at + 1;
        for (int j = 0; j < FC; j++) begin ph[t] = 4; t++; end
        ph[t] = 5; t++;
        while (t < MAXC) begin ph[t] = 0; t++; end
      end
    end
    if (reset_at >= 0)
      for (int c = reset_at + 1; c < MAXC; c++) begin ph[c] = 0; e_err[c] = 1'b0; end
    for (int c = 0; c < MAXC; c++) begin
      e_valve[c] = (ph[c] == 1) ? NS'(1 << ch[c]) : '0;
      e_chan[c]  = (ph[c] == 1 || ph[c] == 2) ? 2'(ch[c]) : 2'd0;
      e_pump[c]  = (ph[c] == 3);
      e_flush[c] = (ph[c] == 4);
      e_busy[c]  = (ph[c] >= 1 && ph[c] <= 4);
      e_done[c]  = (ph[c] == 5);
      e_abt[c]   = (ph[c] == 5) && ab;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rel < MAXC) begin
      chk("valve_en",    rel, 32'(bus.valve_en),    32'(e_valve[rel]));
      chk("cur_chan",    rel, 32'(bus.cur_chan),    32'(e_chan[rel]));
      chk("mix_pump",    rel, 32'(bus.mix_pump),    32'(e_pump[rel]));
      chk("flush_valve", rel, 32'(bus.flush_valve), 32'(e_flush[rel]));
      chk("busy",        rel, 32'(bus.busy),        32'(e_busy[rel]));
      chk("done",        rel, 32'(bus.done),        32'(e_done[rel]));
      chk("aborted",     rel, 32'(bus.aborted),     32'(e_abt[rel]));
      chk("err_empty",   rel, 32'(bus.err_empty),   32'(e_err[rel]));
    end
  end

  task automatic run_scn(input logic [2:0] mask, input int l0, input int l1, input int l2,
                         input int abort_at, input int restart_at, input int reset_at,
                         input int ncyc);
    build_model(mask, l0, l1, l2, abort_at, reset_at);
    for (int r = 0; r < ncyc; r++) begin
      rel    = r;
      chk_en = 1'b1;
      bus.start = (r == 0) || (r == restart_at);
      bus.abort = (r == abort_at);
      rst       = (r == reset_at);
      if (r == 0) begin
        bus.chan_mask = mask;
        bus.dose_len  = {16'(l2), 16'(l1), 16'(l0)};
      end else if (r == 3) begin
        bus.chan_mask = ~mask;
        bus.dose_len  = {3{16'd9}};
      end
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; rst = 1'b0;
  endtask

  int vcount;

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.chan_mask = '0; bus.dose_len = '0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.chan_mask = '0; bus2.dose_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valve", 0, 32'(bus.valve_en), 0);
    chk("reset_busy",  0, 32'(bus.busy),     0);
    chk("reset_done",  0, 32'(bus.done),     0);
    chk("reset_chan",  0, 32'(bus.cur_chan), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full three-channel run; the model itself is pinned to hand-derived cycles.
    build_model(3'b111, 2, 3, 1, -1, -1);
    chk("pin_valve1_c5",  5,  32'(e_valve[5]),  32'h2);
    chk("pin_gap_c9",     9,  32'(e_valve[9]),  32'h0);
    chk("pin_valve2_c10", 10, 32'(e_valve[10]), 32'h4);
    chk("pin_pump_c15",   15, 32'(e_pump[15]),  1);
    chk("pin_flush_c18",  18, 32'(e_flush[18]), 1);
    chk("pin_done_c19",   19, 32'(e_done[19]),  1);
    chk("pin_busy_c19",   19, 32'(e_busy[19]),  0);
    run_scn(3'b111, 2, 3, 1, -1, -1, -1, 22);

    build_model(3'b101, 4, 7, 0, -1, -1);
    chk("pin_mix_c5",   5,  32'(e_pump[5]),  1);
    chk("pin_done_c13", 13, 32'(e_done[13]), 1);
    run_scn(3'b101, 4, 7, 0, -1, -1, -1, 16);

    run_scn(3'b000, 2, 3, 1, -1, -1, -1, 4);
    run_scn(3'b111, 0, 0, 0, -1, -1, -1, 4);

    build_model(3'b111, 2, 3, 1, 5, -1);
    chk("pin_abort_done_c9", 9, 32'(e_abt[9]), 1);
    chk("pin_abort_flush_c6", 6, 32'(e_flush[6]), 1);
    run_scn(3'b111, 2, 3, 1, 5, 3, -1, 12);  // abort mid-dose, restart while busy

    run_scn(3'b111, 2, 3, 1, 3, -1, -1, 10);   // abort in settle
    run_scn(3'b111, 2, 3, 1, 12, -1, -1, 19);  // abort in mix
    run_scn(3'b111, 2, 3, 1, 17, -1, -1, 22);  // abort in flush is ignored
    run_scn(3'b111, 2, 3, 1, 0, -1, -1, 22);   // abort with start in idle is ignored
    run_scn(3'b111, 2, 3, 1, -1, -1, 4, 10);   // reset mid-dose
    run_scn(3'b111, 2, 3, 1, -1, -1, -1, 22);

    // Narrow counter: a 15-cycle dose must not wrap; channel 1 has zero length.
    vcount = 0;
    bus2.chan_mask = 2'b11;
    bus2.dose_len  = {4'd0, 4'd15};
    bus2.start     = 1'b1;
    for (int r = 1; r <= 30; r++) begin
      @(posedge clk); #1;
      bus2.start = 1'b0;
      if (bus2.valve_en[0]) vcount++;
      if (r == 15) chk("w4_valve_last", r, 32'(bus2.valve_en), 32'h1);
      if (r == 16) chk("w4_valve_off",  r, 32'(bus2.valve_en), 32'h0);
      if (r == 16) chk("w4_pump_on",    r, 32'(bus2.mix_pump), 1);
      if (r == 24) chk("w4_done",       r, 32'(bus2.done),     1);
      if (r == 24) chk("w4_aborted",    r, 32'(bus2.aborted),  0);
    end
    chk("w4_valve_cycles", 30, 32'(vcount), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
